// File: rtl/pc_update_ctrl.sv
// PC-update sequencer for the multicycle MIPS datapath: maps one-cycle PC requests to
// PC-source select and write strobes, and runs the exception vector fetch via MDR.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | accepts requests; non-exception requests issue a 1-cycle pcWrite
// EPC_SAVE | epcWrite strobe, datapath presents PC-4 to EPC
// VEC_READ | excMemRead held for MEM_LAT cycles on vecAddr
// MDR_LOAD | mdrWrite strobe captures the handler address
// PC_LOAD  | pcWrite with muxpcsource=4 loads the handler address into PC
module pc_update_ctrl #(
  parameter int         MEM_LAT    = 2,
  parameter logic [7:0] VEC_OPCODE = 8'd253,
  parameter logic [7:0] VEC_OVF    = 8'd254,
  parameter logic [7:0] VEC_DIV0   = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reqSeq,
  input  logic       reqBranch,
  input  logic       brTaken,
  input  logic       reqJump,
  input  logic       reqJr,
  input  logic       reqEret,
  input  logic       excOpcode,
  input  logic       excOvf,
  input  logic       excDiv0,
  output logic [2:0] muxpcsource,
  output logic       pcWrite,
  output logic       epcWrite,
  output logic       excMemRead,
  output logic [7:0] vecAddr,
  output logic       mdrWrite,
  output logic [1:0] excCause,
  output logic       busy,
  output logic       reqDropped
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] EPC_SAVE = 3'd1;
  localparam logic [2:0] VEC_READ = 3'd2;
  localparam logic [2:0] MDR_LOAD = 3'd3;
  localparam logic [2:0] PC_LOAD  = 3'd4;

  localparam logic [2:0] SRC_ALU  = 3'd0;
  localparam logic [2:0] SRC_S    = 3'd1;
  localparam logic [2:0] SRC_SL2  = 3'd2;
  localparam logic [2:0] SRC_EPC  = 3'd3;
  localparam logic [2:0] SRC_MDR  = 3'd4;

  localparam logic [1:0] CAUSE_OPCODE = 2'd1;
  localparam logic [1:0] CAUSE_OVF    = 2'd2;
  localparam logic [1:0] CAUSE_DIV0   = 2'd3;

  // VEC_READ lasts until the down-counter reaches its terminal count of zero
  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  logic [2:0] state;
  logic [2:0] lat_cnt;

  logic       exc_hit;
  logic       req_any;
  logic [1:0] cause_nxt;
  logic [7:0] vec_nxt;

  always_comb begin
    exc_hit   = excOpcode | excOvf | excDiv0;
    req_any   = exc_hit | reqEret | reqJr | reqJump | reqBranch | reqSeq;
    cause_nxt = 2'd0;
    vec_nxt   = 8'd0;
    if (excOpcode) begin
      cause_nxt = CAUSE_OPCODE;
      vec_nxt   = VEC_OPCODE;
    end else if (excOvf) begin
      cause_nxt = CAUSE_OVF;
      vec_nxt   = VEC_OVF;
    end else if (excDiv0) begin
      cause_nxt = CAUSE_DIV0;
      vec_nxt   = VEC_DIV0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lat_cnt     <= 3'd0;
      muxpcsource <= SRC_ALU;
      pcWrite     <= 1'b0;
      epcWrite    <= 1'b0;
      excMemRead  <= 1'b0;
      vecAddr     <= 8'd0;
      mdrWrite    <= 1'b0;
      excCause    <= 2'd0;
      busy        <= 1'b0;
      reqDropped  <= 1'b0;
    end else begin
      pcWrite    <= 1'b0;
      epcWrite   <= 1'b0;
      mdrWrite   <= 1'b0;
      // Anything arriving outside IDLE is discarded but reported
      reqDropped <= (state != IDLE) && req_any;

      case (state)
        IDLE: begin
          if (exc_hit) begin
            state    <= EPC_SAVE;
            epcWrite <= 1'b1;
            busy     <= 1'b1;
            excCause <= cause_nxt;
            vecAddr  <= vec_nxt;
          end else if (reqEret) begin
            pcWrite     <= 1'b1;
            muxpcsource <= SRC_EPC;
          end else if (reqJr) begin
            pcWrite     <= 1'b1;
            muxpcsource <= SRC_ALU;
          end else if (reqJump) begin
            pcWrite     <= 1'b1;
            muxpcsource <= SRC_SL2;
          end else if (reqBranch) begin
            if (brTaken) begin
              pcWrite     <= 1'b1;
              muxpcsource <= SRC_S;
            end
          end else if (reqSeq) begin
            pcWrite     <= 1'b1;
            muxpcsource <= SRC_ALU;
          end
        end

        EPC_SAVE: begin
          state      <= VEC_READ;
          excMemRead <= 1'b1;
          lat_cnt    <= LAT_LOAD;
        end

        VEC_READ: begin
          if (lat_cnt == 3'd0) begin
            state      <= MDR_LOAD;
            excMemRead <= 1'b0;
            mdrWrite   <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        MDR_LOAD: begin
          state       <= PC_LOAD;
          pcWrite     <= 1'b1;
          muxpcsource <= SRC_MDR;
        end

        PC_LOAD: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          lat_cnt    <= 3'd0;
          excMemRead <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Directed self-checking bench for pc_update_ctrl with the default MEM_LAT=2.
module tb_pc_update_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       reqSeq, reqBranch, brTaken, reqJump, reqJr, reqEret;
  logic       excOpcode, excOvf, excDiv0;
  logic [2:0] muxpcsource;
  logic       pcWrite, epcWrite, excMemRead, mdrWrite, busy, reqDropped;
  logic [7:0] vecAddr;
  logic [1:0] excCause;

  int checks = 0;
  int passes = 0;

  // {epcWrite, excMemRead, mdrWrite, pcWrite, busy} for cycles +1..+6 of an exception
  logic [4:0] exc_tbl [1:6];

  pc_update_ctrl dut (
    .clk(clk), .reset(reset),
    .reqSeq(reqSeq), .reqBranch(reqBranch), .brTaken(brTaken),
    .reqJump(reqJump), .reqJr(reqJr), .reqEret(reqEret),
    .excOpcode(excOpcode), .excOvf(excOvf), .excDiv0(excDiv0),
    .muxpcsource(muxpcsource), .pcWrite(pcWrite), .epcWrite(epcWrite),
    .excMemRead(excMemRead), .vecAddr(vecAddr), .mdrWrite(mdrWrite),
    .excCause(excCause), .busy(busy), .reqDropped(reqDropped)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reqSeq = 0; reqBranch = 0; brTaken = 0; reqJump = 0; reqJr = 0;
    reqEret = 0; excOpcode = 0; excOvf = 0; excDiv0 = 0;
  endtask

  task automatic test_reset();
    logic [20:0] obs;
    clear_inputs();
    reset = 1;
    step();
    step();
    obs = {muxpcsource, pcWrite, epcWrite, excMemRead, vecAddr, mdrWrite, excCause, busy, reqDropped};
    checks++;
    if (obs !== 21'd0) $display("FAIL reset_outputs: got %h expected 0", obs);
    else passes++;
    reset = 0;
  endtask

  task automatic test_seq();
    reqSeq = 1;
    step();
    reqSeq = 0;
    checks++;
    if ({pcWrite, muxpcsource} !== {1'b1, 3'd0})
      $display("FAIL seq_first: pcWrite=%0b mux=%0d expected 1/0", pcWrite, muxpcsource);
    else passes++;
    step();
    checks++;
    if ({pcWrite, muxpcsource} !== {1'b0, 3'd0})
      $display("FAIL seq_second: pcWrite=%0b mux=%0d expected 0/0", pcWrite, muxpcsource);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_v [0:4];
    exp_v[0] = {1'b1, 3'd1};
    exp_v[1] = {1'b0, 3'd1};
    exp_v[2] = {1'b1, 3'd2};
    exp_v[3] = {1'b1, 3'd3};
    exp_v[4] = {1'b0, 3'd3};
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      case (i)
        0: begin reqBranch = 1; brTaken = 1; end
        1: begin reqBranch = 1; brTaken = 0; end
        2: reqJump = 1;
        3: reqEret = 1;
        default: ;
      endcase
      step();
      checks++;
      if ({pcWrite, muxpcsource} !== exp_v[i])
        $display("FAIL b2b_%0d: pcWrite=%0b mux=%0d expected %0b/%0d",
                 i, pcWrite, muxpcsource, exp_v[i][3], exp_v[i][2:0]);
      else passes++;
    end
    clear_inputs();
  endtask

  task automatic test_priority();
    logic [2:0] exp_m [0:2];
    exp_m[0] = 3'd3;
    exp_m[1] = 3'd2;
    exp_m[2] = 3'd1;
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      case (i)
        0: begin reqEret = 1; reqJr = 1; reqSeq = 1; end
        1: begin reqJump = 1; reqBranch = 1; brTaken = 1; end
        default: begin reqBranch = 1; brTaken = 1; reqSeq = 1; end
      endcase
      step();
      checks++;
      if ({pcWrite, muxpcsource, reqDropped} !== {1'b1, exp_m[i], 1'b0})
        $display("FAIL prio_%0d: pcWrite=%0b mux=%0d dropped=%0b expected 1/%0d/0",
                 i, pcWrite, muxpcsource, reqDropped, exp_m[i]);
      else passes++;
    end
    clear_inputs();
    step();
  endtask

  task automatic test_exc_ovf();
    int pcw_cnt = 0;
    excOvf = 1;
    reqJump = 1;
    for (int k = 1; k <= 6; k++) begin
      step();
      clear_inputs();
      pcw_cnt += int'(pcWrite);
      checks++;
      if ({epcWrite, excMemRead, mdrWrite, pcWrite, busy} !== exc_tbl[k])
        $display("FAIL ovf_strobes_c%0d: got %b expected %b",
                 k, {epcWrite, excMemRead, mdrWrite, pcWrite, busy}, exc_tbl[k]);
      else passes++;
      if (k == 2 || k == 3) begin
        checks++;
        if (vecAddr !== 8'd254) $display("FAIL ovf_vecaddr_c%0d: got %0d expected 254", k, vecAddr);
        else passes++;
      end
      if (k == 5) begin
        checks++;
        if (muxpcsource !== 3'd4) $display("FAIL ovf_mux: got %0d expected 4", muxpcsource);
        else passes++;
      end
    end
    checks++;
    if (excCause !== 2'd2) $display("FAIL ovf_cause: got %0d expected 2", excCause);
    else passes++;
    checks++;
    if (pcw_cnt != 1) $display("FAIL ovf_pcwrite_count: got %0d expected 1", pcw_cnt);
    else passes++;
  endtask

  task automatic test_exc_all();
    excOpcode = 1; excOvf = 1; excDiv0 = 1;
    for (int k = 1; k <= 6; k++) begin
      step();
      clear_inputs();
      checks++;
      if ({epcWrite, excMemRead, mdrWrite, pcWrite, busy} !== exc_tbl[k])
        $display("FAIL all_strobes_c%0d: got %b expected %b",
                 k, {epcWrite, excMemRead, mdrWrite, pcWrite, busy}, exc_tbl[k]);
      else passes++;
      if (k == 2) begin
        checks++;
        if ({vecAddr, excCause} !== {8'd253, 2'd1})
          $display("FAIL all_vec_cause: vecAddr=%0d cause=%0d expected 253/1", vecAddr, excCause);
        else passes++;
      end
    end
  endtask

  task automatic test_drop_during_vec_read();
    int pcw_cnt = 0;
    int drop_cnt = 0;
    excDiv0 = 1;
    for (int k = 1; k <= 7; k++) begin
      step();
      clear_inputs();
      if (k == 2) reqSeq = 1;
      pcw_cnt  += int'(pcWrite);
      drop_cnt += int'(reqDropped);
      checks++;
      if ({epcWrite, excMemRead, mdrWrite, pcWrite, busy} !== ((k <= 6) ? exc_tbl[k] : 5'b0))
        $display("FAIL drop_strobes_c%0d: got %b", k, {epcWrite, excMemRead, mdrWrite, pcWrite, busy});
      else passes++;
      if (k == 3) begin
        checks++;
        if ({reqDropped, vecAddr} !== {1'b1, 8'd255})
          $display("FAIL drop_pulse: dropped=%0b vecAddr=%0d expected 1/255", reqDropped, vecAddr);
        else passes++;
      end
    end
    checks++;
    if (drop_cnt != 1 || pcw_cnt != 1)
      $display("FAIL drop_counts: dropped=%0d pcWrite=%0d expected 1/1", drop_cnt, pcw_cnt);
    else passes++;
    checks++;
    if (excCause !== 2'd3) $display("FAIL drop_cause: got %0d expected 3", excCause);
    else passes++;
  endtask

  task automatic test_reset_mid_exception();
    int pcw_cnt = 0;
    logic [20:0] obs;
    excOpcode = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      clear_inputs();
    end
    checks++;
    if (mdrWrite !== 1'b1) $display("FAIL rst_mid_mdr: mdrWrite=%0b expected 1", mdrWrite);
    else passes++;
    reset = 1;
    step();
    reset = 0;
    obs = {muxpcsource, pcWrite, epcWrite, excMemRead, vecAddr, mdrWrite, excCause, busy, reqDropped};
    checks++;
    if (obs !== 21'd0) $display("FAIL rst_mid_outputs: got %h expected 0", obs);
    else passes++;
    for (int k = 0; k < 3; k++) begin
      step();
      pcw_cnt += int'(pcWrite);
    end
    checks++;
    if (pcw_cnt != 0 || busy !== 1'b0)
      $display("FAIL rst_mid_idle: pcWrite count=%0d busy=%0b expected 0/0", pcw_cnt, busy);
    else passes++;
    reqJr = 1;
    step();
    clear_inputs();
    checks++;
    if ({pcWrite, muxpcsource} !== {1'b1, 3'd0})
      $display("FAIL rst_mid_jr: pcWrite=%0b mux=%0d expected 1/0", pcWrite, muxpcsource);
    else passes++;
  endtask

  initial begin
    exc_tbl[1] = 5'b10001;
    exc_tbl[2] = 5'b01001;
    exc_tbl[3] = 5'b01001;
    exc_tbl[4] = 5'b00101;
    exc_tbl[5] = 5'b00011;
    exc_tbl[6] = 5'b00000;
    reset = 1;
    clear_inputs();
    test_reset();
    test_seq();
    test_back_to_back();
    test_priority();
    test_exc_ovf();
    test_exc_all();
    test_drop_during_vec_read();
    test_reset_mid_exception();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
